// File: rtl/mux_n_to_1_rr.sv
// N-to-1 packet-aware round-robin multiplexer with a one-deep registered output
// stage. A packet (beats up to and including in_last) holds the grant until it
// completes. A force override picks a fixed channel while arbitration is open.

// Per-channel slice: decodes the grant for this lane, produces the lane's
// ready/transfer strobes and a zero-masked copy of its beat for the OR-mux.
module mux_n_to_1_rr_lane #(
   parameter int WIDTH = 8,
   parameter int SEL_W = 2,
   parameter int IDX   = 0
)(
   input  logic [WIDTH-1:0] data,
   input  logic             valid,
   input  logic             last,
   input  logic [SEL_W-1:0] grant_idx,
   input  logic             grant_ok,
   input  logic             load_en,
   output logic             ready,
   output logic             xfer,
   output logic [WIDTH-1:0] data_m,
   output logic             last_m
);

   logic hit;

   // Lane is addressed by the current grant
   assign hit    = grant_ok && (grant_idx == SEL_W'(IDX));
   assign ready  = hit && load_en;
   assign xfer   = ready && valid;
   // Non-transferring lanes contribute zero so the top can OR-reduce
   assign data_m = xfer ? data : '0;
   assign last_m = xfer && last;

endmodule

module mux_n_to_1_rr #(
   parameter int WIDTH  = 8,
   parameter int NUM_IN = 4,
   parameter int SEL_W  = 2
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [NUM_IN-1:0]       in_valid,
   input  logic [NUM_IN-1:0]       in_last,
   output logic [NUM_IN-1:0]       in_ready,
   input  logic                    force_en,
   input  logic [SEL_W-1:0]        force_sel,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_valid,
   output logic                    out_last,
   output logic [SEL_W-1:0]        out_sel,
   input  logic                    out_ready
);

   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

   state_t                        state;
   logic [SEL_W-1:0]              ptr;
   logic [SEL_W-1:0]              lock_idx;
   logic [SEL_W-1:0]              grant_idx;
   logic                          grant_ok;
   logic                          load_en;
   logic                          xfer;
   logic [WIDTH-1:0]              mux_data;
   logic                          mux_last;
   logic [NUM_IN-1:0]             lane_xfer;
   logic [NUM_IN-1:0]             lane_last;
   logic [NUM_IN-1:0][WIDTH-1:0]  lane_data;

   // Output stage can take a new beat when empty or draining this cycle
   assign load_en = !out_valid || out_ready;

   // Grant selection: locked channel, forced channel, or round-robin search
   always_comb begin
      int idx;
      grant_idx = '0;
      grant_ok  = 1'b0;
      idx       = 0;
      if (state == LOCKED) begin
         // Ready follows load_en regardless of in_valid while locked
         grant_idx = lock_idx;
         grant_ok  = 1'b1;
      end else if (force_en) begin
         // Out-of-range force_sel matches no lane, so nothing is granted
         for (int i = 0; i < NUM_IN; i++) begin
            if (force_sel == SEL_W'(i) && in_valid[i]) begin
               grant_idx = SEL_W'(i);
               grant_ok  = 1'b1;
            end
         end
      end else begin
         // First valid channel starting just after the last packet winner
         for (int k = 1; k <= NUM_IN; k++) begin
            idx = (int'(ptr) + k) % NUM_IN;
            if (!grant_ok && in_valid[idx]) begin
               grant_idx = SEL_W'(idx);
               grant_ok  = 1'b1;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_IN; g++) begin : g_lane
      mux_n_to_1_rr_lane #(
         .WIDTH (WIDTH),
         .SEL_W (SEL_W),
         .IDX   (g)
      ) u_lane (
         .data      (in_data[g*WIDTH +: WIDTH]),
         .valid     (in_valid[g]),
         .last      (in_last[g]),
         .grant_idx (grant_idx),
         .grant_ok  (grant_ok),
         .load_en   (load_en),
         .ready     (in_ready[g]),
         .xfer      (lane_xfer[g]),
         .data_m    (lane_data[g]),
         .last_m    (lane_last[g])
      );
   end

   // OR-reduce the masked lanes; at most one lane transfers per cycle
   always_comb begin
      mux_data = '0;
      for (int i = 0; i < NUM_IN; i++) mux_data = mux_data | lane_data[i];
   end

   assign mux_last = |lane_last;
   assign xfer     = |lane_xfer;

   // Packet FSM, arbitration pointer and registered output stage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= SEL_W'(NUM_IN - 1);
         lock_idx  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_sel   <= '0;
      end else begin
         if (load_en) begin
            out_valid <= xfer;
            if (xfer) begin
               out_data <= mux_data;
               out_last <= mux_last;
               out_sel  <= grant_idx;
            end
         end
         case (state)
            IDLE: begin
               if (xfer) begin
                  if (mux_last) begin
                     ptr <= grant_idx;
                  end else begin
                     state    <= LOCKED;
                     lock_idx <= grant_idx;
                  end
               end
            end
            LOCKED: begin
               if (xfer && mux_last) begin
                  state <= IDLE;
                  ptr   <= lock_idx;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mux_n_to_1_rr.sv
// Bench for mux_n_to_1_rr (WIDTH=8, NUM_IN=4, SEL_W=3 so force_sel can go out
// of range). Stimulus pushes expected beats into a scoreboard; a monitor pops
// and compares on every output transfer.
module tb_mux_n_to_1_rr;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] in_data = '0;
   logic [3:0]  in_valid = '0;
   logic [3:0]  in_last = '0;
   logic [3:0]  in_ready;
   logic        force_en = 1'b0;
   logic [2:0]  force_sel = '0;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_last;
   logic [2:0]  out_sel;
   logic        out_ready = 1'b1;

   mux_n_to_1_rr #(.WIDTH(8), .NUM_IN(4), .SEL_W(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .force_en  (force_en),
      .force_sel (force_sel),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] sel;
      logic       last;
      logic [7:0] data;
   } exp_t;

   int   nerr = 0;
   int   nchk = 0;
   int   beats_seen = 0;
   bit   soak = 0;
   exp_t exp_q[$];

   // Per-channel source FIFOs {last,data} and soak expectation FIFOs
   logic [8:0] cmem [4][1024];
   int         rd [4];
   int         wr [4];
   logic [8:0] emem [4][1024];
   int         erd [4];
   int         ewr [4];
   int         wait_pk [4];
   bit         in_pkt = 0;
   logic [2:0] pkt_ch = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      nchk++;
      if (act !== req) begin
         nerr++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic refresh();
      for (int i = 0; i < 4; i++) begin
         if (rd[i] != wr[i]) begin
            in_valid[i]       = 1'b1;
            in_data[i*8 +: 8] = cmem[i][rd[i] & 1023][7:0];
            in_last[i]        = cmem[i][rd[i] & 1023][8];
         end else begin
            in_valid[i]       = 1'b0;
            in_data[i*8 +: 8] = 8'h00;
            in_last[i]        = 1'b0;
         end
      end
   endtask

   task automatic push_beat(input int ch, input logic [7:0] d, input logic l);
      cmem[ch][wr[ch] & 1023] = {l, d};
      wr[ch]++;
   endtask

   task automatic exp_beat(input int ch, input logic [7:0] d, input logic l);
      exp_t e;
      e.sel  = 3'(ch);
      e.last = l;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         tick();
         n++;
      end
      tick();
      chk(name, exp_q.size(), 0);
   endtask

   // Source driver: retire beats the DUT accepted at the edge, then re-present heads
   initial begin
      logic [3:0] acc;
      for (int i = 0; i < 4; i++) begin
         rd[i] = 0; wr[i] = 0; erd[i] = 0; ewr[i] = 0; wait_pk[i] = 0;
      end
      forever begin
         @(negedge clk);
         acc = in_valid & in_ready;
         @(posedge clk);
         if (rst) acc = '0;
         #1;
         for (int i = 0; i < 4; i++) if (acc[i]) rd[i]++;
         refresh();
      end
   end

   // Monitor: compare every output transfer against the scoreboard
   always @(negedge clk) begin
      exp_t e;
      int   ch;
      if (!rst && out_valid && out_ready) begin
         beats_seen++;
         if (!soak) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", {out_sel, out_last, out_data}, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               chk("beat", {out_sel, out_last, out_data}, 32'(e));
            end
         end else begin
            ch = int'(out_sel);
            if (ch > 3) begin
               chk("soak_sel_range", 32'(ch), 32'(3));
            end else if (erd[ch] == ewr[ch]) begin
               chk("soak_extra_beat", {out_sel, out_last, out_data}, 32'hFFFF_FFFF);
            end else begin
               chk("soak_order", {out_last, out_data}, 32'(emem[ch][erd[ch] & 1023]));
               erd[ch]++;
               chk("soak_interleave", 32'(in_pkt && out_sel != pkt_ch), 0);
               in_pkt = !out_last;
               pkt_ch = out_sel;
               wait_pk[ch] = 0;
               if (out_last) begin
                  for (int i = 0; i < 4; i++) begin
                     if (i != ch && erd[i] != ewr[i]) begin
                        wait_pk[i]++;
                        chk("soak_starve", 32'(wait_pk[i] > 3), 0);
                     end
                  end
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      int len;
      int seqn [4];
      int pend;
      int n;
      refresh();

      // Reset state
      mid();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_sel", out_sel, 0);
      chk("rst_in_ready", in_ready, 0);
      tick();
      rst = 1'b0;
      tick();

      // Single-beat round robin, two rounds from channel 0
      for (int i = 0; i < 4; i++) push_beat(i, 8'hA0 + 8'(i), 1'b1);
      for (int i = 0; i < 4; i++) push_beat(i, 8'hB0 + 8'(i), 1'b1);
      refresh();
      for (int i = 0; i < 4; i++) exp_beat(i, 8'hA0 + 8'(i), 1'b1);
      for (int i = 0; i < 4; i++) exp_beat(i, 8'hB0 + 8'(i), 1'b1);
      n = beats_seen;
      mid();
      chk("rr_first_ready", in_ready, 4'b0001);
      chk("rr_no_valid_yet", out_valid, 0);
      mid();
      chk("rr_latency_valid", out_valid, 1);
      chk("rr_latency_sel", out_sel, 0);
      repeat (7) mid();
      chk("rr_consecutive", beats_seen - n, 8);
      drain("rr_drain");

      // Packet lock: prime ptr to ch1, then ch2 packet beats ch3 and ch0
      push_beat(1, 8'h1F, 1'b1);
      refresh();
      exp_beat(1, 8'h1F, 1'b1);
      drain("prime_drain");
      push_beat(2, 8'h11, 1'b0);
      push_beat(2, 8'h22, 1'b0);
      push_beat(2, 8'h33, 1'b1);
      push_beat(0, 8'h0A, 1'b1);
      push_beat(3, 8'h3A, 1'b1);
      refresh();
      exp_beat(2, 8'h11, 1'b0);
      exp_beat(2, 8'h22, 1'b0);
      exp_beat(2, 8'h33, 1'b1);
      exp_beat(3, 8'h3A, 1'b1);
      exp_beat(0, 8'h0A, 1'b1);
      mid();
      chk("lock_grant", in_ready, 4'b0100);
      mid();
      chk("lock_hold", in_ready, 4'b0100);
      drain("lock_drain");

      // Backpressure on a held beat
      push_beat(1, 8'h55, 1'b1);
      push_beat(1, 8'h66, 1'b1);
      refresh();
      out_ready = 1'b0;
      exp_beat(1, 8'h55, 1'b1);
      exp_beat(1, 8'h66, 1'b1);
      mid();
      chk("bp_first_ready", in_ready, 4'b0010);
      for (int c = 0; c < 3; c++) begin
         mid();
         chk("bp_valid", out_valid, 1);
         chk("bp_data", out_data, 8'h55);
         chk("bp_in_ready", in_ready, 4'b0000);
      end
      tick();
      out_ready = 1'b1;
      drain("bp_drain");

      // Force override, in range then out of range
      force_en  = 1'b1;
      force_sel = 3'd3;
      push_beat(1, 8'h1B, 1'b1);
      push_beat(3, 8'h3B, 1'b1);
      push_beat(3, 8'h3C, 1'b1);
      refresh();
      exp_beat(3, 8'h3B, 1'b1);
      exp_beat(3, 8'h3C, 1'b1);
      mid();
      chk("force_grant", in_ready, 4'b1000);
      mid();
      chk("force_grant2", in_ready, 4'b1000);
      tick();
      force_sel = 3'd5;
      mid();
      chk("force_oor_ready", in_ready, 4'b0000);
      mid();
      chk("force_oor_drained", out_valid, 0);
      chk("force_oor_ready2", in_ready, 4'b0000);
      tick();
      force_en = 1'b0;
      exp_beat(1, 8'h1B, 1'b1);
      drain("force_drain");

      // Reset in the middle of a ch1 packet
      push_beat(1, 8'h71, 1'b0);
      push_beat(1, 8'h72, 1'b0);
      push_beat(1, 8'h73, 1'b1);
      refresh();
      exp_beat(1, 8'h71, 1'b0);
      mid();
      chk("mp_grant", in_ready, 4'b0010);
      mid();
      chk("mp_locked", in_ready, 4'b0010);
      rst = 1'b1;
      #1;
      chk("mp_rst_valid", out_valid, 0);
      chk("mp_rst_data", out_data, 0);
      chk("mp_rst_sel", out_sel, 0);
      chk("mp_rst_last", out_last, 0);
      rd[1] = wr[1];
      push_beat(1, 8'h81, 1'b1);
      push_beat(2, 8'h82, 1'b1);
      refresh();
      exp_beat(1, 8'h81, 1'b1);
      exp_beat(2, 8'h82, 1'b1);
      tick();
      tick();
      rst = 1'b0;
      mid();
      chk("mp_post_grant", in_ready, 4'b0010);
      drain("mp_drain");

      // Random soak with per-channel scoreboards
      soak   = 1;
      in_pkt = 0;
      for (int i = 0; i < 4; i++) begin
         seqn[i] = 0;
         wait_pk[i] = 0;
      end
      for (int c = 0; c < 400; c++) begin
         tick();
         for (int ch = 0; ch < 4; ch++) begin
            if (rd[ch] == wr[ch] && $urandom_range(0, 2) == 0) begin
               len = $urandom_range(1, 3);
               for (int b = 0; b < len; b++) begin
                  push_beat(ch, 8'(ch * 64 + (seqn[ch] % 64)), b == len - 1);
                  emem[ch][ewr[ch] & 1023] = {b == len - 1, 8'(ch * 64 + (seqn[ch] % 64))};
                  ewr[ch]++;
                  seqn[ch]++;
               end
            end
         end
         out_ready = ($urandom_range(0, 3) != 0);
         refresh();
      end
      out_ready = 1'b1;
      n = 0;
      pend = 1;
      while (pend != 0 && n < 200) begin
         tick();
         n++;
         pend = 0;
         for (int i = 0; i < 4; i++) pend += ewr[i] - erd[i];
      end
      chk("soak_drain", pend, 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/mux_n_to_1_rr.md
MUX_N_TO_1_RR -- requirements
Module: mux_n_to_1_rr

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the data width per input channel (WIDTH >= 1).
REQ-002 Parameter NUM_IN, default 4, SHALL set the input channel count (2..16).
REQ-003 Parameter SEL_W, default 2, SHALL set the width of channel-index ports, with SEL_W >= clog2(NUM_IN).
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 in_data  input  NUM_IN*WIDTH  SHALL carry channel i on bits [(i+1)*WIDTH-1 : i*WIDTH].
REQ-007 in_valid  input  NUM_IN  SHALL be the per-channel beat-valid.
REQ-008 in_last  input  NUM_IN  SHALL be the per-channel last-beat-of-packet flag.
REQ-009 in_ready  output  NUM_IN  SHALL be the per-channel accept signal.
REQ-010 force_en  input  1  SHALL enable the fixed-select override.
REQ-011 force_sel  input  SEL_W  SHALL be the channel selected while force_en=1.
REQ-012 out_data  output  WIDTH  SHALL be the registered output beat.
REQ-013 out_valid  output  1  SHALL be the registered output-valid.
REQ-014 out_last  output  1  SHALL be the registered last flag of the output beat.
REQ-015 out_sel  output  SEL_W  SHALL be the source channel of the current output beat.
REQ-016 out_ready  input  1  SHALL be the downstream accept signal.

Function
REQ-017 A transfer on a channel SHALL occur in a cycle where in_valid[i]=1 and in_ready[i]=1; an output transfer SHALL occur when out_valid=1 and out_ready=1.
REQ-018 load_en SHALL be (!out_valid || out_ready); the output register SHALL load only when load_en=1 and an input transfer occurs. Otherwise it SHALL hold out_data, out_last and out_sel stable. If no input transfer occurs while load_en=1, out_valid SHALL clear.
REQ-019 Latency SHALL be one cycle from input transfer to out_valid; sustained throughput SHALL be one beat per cycle with out_ready=1.
REQ-020 The FSM SHALL have two states. In IDLE, arbitration is open. In LOCKED, a packet is in progress on lock_idx.
REQ-021 In IDLE with force_en=0, grant SHALL go to the first channel with in_valid=1, searching upward from (ptr+1) mod NUM_IN with wrap-around.
REQ-022 In IDLE with force_en=1, grant SHALL be force_sel only if in_valid[force_sel]=1. If force_sel >= NUM_IN, no grant SHALL be made.
REQ-023 In IDLE, in_ready[i] SHALL be 1 only for the granted channel and only when load_en=1. All other bits SHALL be 0.
REQ-024 An IDLE transfer with in_last=1 SHALL stay in IDLE and set ptr to the granted channel.
REQ-025 An IDLE transfer with in_last=0 SHALL move to LOCKED and set lock_idx to the granted channel.
REQ-026 In LOCKED, in_ready[lock_idx] SHALL equal load_en and all other bits SHALL be 0. force_en and force_sel SHALL be ignored. No other channel SHALL interleave.
REQ-027 A LOCKED transfer with in_last=1 SHALL return the FSM to IDLE and set ptr to lock_idx.
REQ-028 in_ready SHALL depend combinationally on state, in_valid, force inputs, out_valid and out_ready, and on nothing else.
REQ-029 When out_valid=1 and out_ready=0, all in_ready bits SHALL be 0.

Reset
REQ-030 While rst=1, independent of clk, the block SHALL force: out_valid=0, out_data=0, out_last=0, out_sel=0, state=IDLE, lock_idx=0, ptr=NUM_IN-1 (channel 0 has first priority).
REQ-031 A reset asserted mid-packet SHALL abandon the packet. The first grant after release SHALL be made from IDLE with ptr=NUM_IN-1.

Verification (WIDTH=8, NUM_IN=4)
REQ-032 Single-beat round-robin: all in_valid=1, in_last=1, out_ready=1, data 0xA0..0xA3. The bench SHALL see out_sel 0,1,2,3,0 on consecutive cycles, first out_valid one cycle after the first transfer.
REQ-033 Packet lock: ch2 sends 0x11, 0x22, 0x33 with last on 0x33 while ch0 and ch3 are valid. The bench SHALL see three contiguous ch2 beats, then ch3, then ch0.
REQ-034 Backpressure: out_ready=0 for 3 cycles with out_valid=1, out_data=0x55. The bench SHALL see out_data hold 0x55, in_ready=0000 throughout, and no beat lost or duplicated after release.
REQ-035 Force: force_en=1, force_sel=3, ch1 and ch3 valid. The bench SHALL see only ch3 granted. With force_sel=5 (out of range), no grant SHALL occur; in_ready SHALL be 0000 and out_valid SHALL clear once drained.
REQ-036 Reset mid-packet: rst pulses while LOCKED on ch1. The bench SHALL see outputs clear immediately and, with ch1 and ch2 valid after release, the next grant go to ch1.
REQ-037 Random soak: random valid, last and out_ready on all 4 channels. A scoreboard SHALL confirm per-channel ordering, no interleaving inside a packet, and no starvation beyond 3 packets of other channels.
